// File: rtl/fft_bitrev_buffer.sv
// ============================================================================
// fft_bitrev_buffer
//
// Single-buffer bit-reversal reorder stage in front of the FFT butterflies.
// A natural-order input frame of N = 2**N_LOG2 samples is written through
// RAM port A to bit-reversed addresses. The RAM is then read sequentially
// through port B and emitted as a valid/ready stream, so that
// out[k] = in[bitrev(k)]. The RAM is external, with 1-cycle read latency.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   s_valid    input sample valid
//   s_ready    input ready (LOAD state only)
//   s_data     input sample
//   m_valid    output sample valid
//   m_ready    downstream ready
//   m_data     output sample (0 when m_valid is low)
//   m_last     marks the word read from address N-1
//   busy       high while the frame is draining
//   ram_ena    port A enable
//   ram_wea    port A write enable
//   ram_addra  port A address (bit-reversed write index)
//   ram_dina   port A write data
//   ram_enb    port B enable
//   ram_web    port B write enable, tied low
//   ram_addrb  port B address (sequential read index)
//   ram_doutb  port B read data, valid the cycle after ram_enb
// ============================================================================
module fft_bitrev_buffer #(
   parameter int N_LOG2 = 10,
   parameter int DW     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DW-1:0]     m_data,
   output logic              m_last,
   output logic              busy,
   output logic              ram_ena,
   output logic              ram_wea,
   output logic [N_LOG2-1:0] ram_addra,
   output logic [DW-1:0]     ram_dina,
   output logic              ram_enb,
   output logic              ram_web,
   output logic [N_LOG2-1:0] ram_addrb,
   input  logic [DW-1:0]     ram_doutb
);

   typedef enum logic {LOAD, DRAIN} state_t;

   state_t              state, state_n;
   logic                ready_q;
   logic [N_LOG2-1:0]   wr_cnt;
   // One extra bit so "all N reads issued" is simply the MSB.
   logic [N_LOG2:0]     rd_cnt;

   // Read pipeline: one read can be in the RAM at a time per cycle.
   logic                inflight;
   logic                inflight_last;

   // Two-entry skid FIFO holding {last, data}.
   logic [DW-1:0]       fifo_data [2];
   logic                fifo_last [2];
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count;

   logic                wr_fire;
   logic                pop;
   logic                rd_issue;
   logic                last_word;
   logic [2:0]          occ;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
      return r;
   endfunction

   // ready_q is only ever high in LOAD, so it alone qualifies a write.
   assign wr_fire   = s_valid && ready_q;
   assign pop       = (count != 2'd0) && m_ready;
   assign last_word = pop && fifo_last[rd_ptr];

   // Occupancy after this cycle's pop. Counting the pop lets a new read
   // issue every cycle when the sink keeps up, while still guaranteeing
   // that buffered plus in-flight words never exceed the two FIFO slots.
   assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign rd_issue = (state == DRAIN) && !rd_cnt[N_LOG2] && (occ < 3'd2);

   // NOTE: every signal written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_n = state;
      unique case (state)
         LOAD:  if (wr_fire && (&wr_cnt)) state_n = DRAIN;
         DRAIN: if (last_word)            state_n = LOAD;
         default:                         state_n = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= LOAD;
         ready_q       <= 1'b0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= 2'd0;
         // NOTE: the FIFO storage is only two entries, so it is reset to
         // give a defined head value; a large RAM array would not be.
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         state   <= state_n;
         ready_q <= (state_n == LOAD);

         if (wr_fire) wr_cnt <= wr_cnt + 1'b1;

         if (last_word)     rd_cnt <= '0;
         else if (rd_issue) rd_cnt <= rd_cnt + 1'b1;

         inflight      <= rd_issue;
         inflight_last <= rd_issue && (&rd_cnt[N_LOG2-1:0]);

         // Capture the RAM word the cycle after its read issued.
         if (inflight) begin
            fifo_data[wr_ptr] <= ram_doutb;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;

         unique case ({inflight, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign s_ready   = ready_q;
   assign busy      = (state == DRAIN);

   assign m_valid   = (count != 2'd0);
   assign m_data    = m_valid ? fifo_data[rd_ptr] : '0;
   assign m_last    = m_valid && fifo_last[rd_ptr];

   // Address/data buses are forced to 0 when their port is idle.
   assign ram_ena   = wr_fire;
   assign ram_wea   = wr_fire;
   assign ram_addra = wr_fire ? bitrev(wr_cnt) : '0;
   assign ram_dina  = wr_fire ? s_data : '0;

   assign ram_enb   = rd_issue;
   assign ram_web   = 1'b0;
   assign ram_addrb = rd_issue ? rd_cnt[N_LOG2-1:0] : '0;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// ============================================================================
// tb_fft_bitrev_buffer
//
// Two instances: an 8-word frame (N_LOG2=3) for the directed protocol cases
// and the default 1024-word frame for the long-stream case. Each has a
// behavioural dual-port RAM with 1-cycle read latency.
// ============================================================================
module tb_fft_bitrev_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hand-computed 3-bit bit-reversal table.
   int rev8 [8];
   initial rev8 = '{0, 4, 2, 6, 1, 5, 3, 7};

   // ---------------------------------------------------------------- N=8 DUT
   logic        rst3, s_valid3, s_ready3, m_valid3, m_ready3, m_last3, busy3;
   logic [15:0] s_data3, m_data3, ram_dina3, ram_doutb3;
   logic        ram_ena3, ram_wea3, ram_enb3, ram_web3;
   logic [2:0]  ram_addra3, ram_addrb3;
   logic [15:0] mem3 [8];

   fft_bitrev_buffer #(.N_LOG2(3), .DW(16)) dut3 (
      .clk(clk), .rst(rst3),
      .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
      .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .m_last(m_last3),
      .busy(busy3),
      .ram_ena(ram_ena3), .ram_wea(ram_wea3), .ram_addra(ram_addra3), .ram_dina(ram_dina3),
      .ram_enb(ram_enb3), .ram_web(ram_web3), .ram_addrb(ram_addrb3), .ram_doutb(ram_doutb3)
   );

   always @(posedge clk) begin
      if (ram_ena3 && ram_wea3) mem3[ram_addra3] <= ram_dina3;
      if (ram_enb3)             ram_doutb3       <= mem3[ram_addrb3];
   end

   // ------------------------------------------------------------- N=1024 DUT
   logic        rst10, s_valid10, s_ready10, m_valid10, m_ready10, m_last10, busy10;
   logic [15:0] s_data10, m_data10, ram_dina10, ram_doutb10;
   logic        ram_ena10, ram_wea10, ram_enb10, ram_web10;
   logic [9:0]  ram_addra10, ram_addrb10;
   logic [15:0] mem10 [1024];

   fft_bitrev_buffer #(.N_LOG2(10), .DW(16)) dut10 (
      .clk(clk), .rst(rst10),
      .s_valid(s_valid10), .s_ready(s_ready10), .s_data(s_data10),
      .m_valid(m_valid10), .m_ready(m_ready10), .m_data(m_data10), .m_last(m_last10),
      .busy(busy10),
      .ram_ena(ram_ena10), .ram_wea(ram_wea10), .ram_addra(ram_addra10), .ram_dina(ram_dina10),
      .ram_enb(ram_enb10), .ram_web(ram_web10), .ram_addrb(ram_addrb10), .ram_doutb(ram_doutb10)
   );

   always @(posedge clk) begin
      if (ram_ena10 && ram_wea10) mem10[ram_addra10] <= ram_dina10;
      if (ram_enb10)              ram_doutb10        <= mem10[ram_addrb10];
   end

   // ------------------------------------------------- N=8 protocol monitor
   // Sampled on the falling edge; tracks write index, expected busy window,
   // reads issued vs. words popped, stall stability and collected outputs.
   int          wr_seen  = 0;
   bit          busy_exp = 1'b0;
   int          issued   = 0;
   int          popped   = 0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic        prev_last;
   logic [15:0] got_d [$];
   logic        got_l [$];

   always @(negedge clk) begin
      logic hs_in;
      if (rst3) begin
         wr_seen    = 0;
         busy_exp   = 1'b0;
         issued     = 0;
         popped     = 0;
         prev_stall = 1'b0;
         got_d.delete();
         got_l.delete();
      end else begin
         hs_in = s_valid3 && s_ready3;
         check("busy_window", 32'(busy3), 32'(busy_exp));
         if (busy_exp) check("s_ready_in_drain", 32'(s_ready3), 32'd0);
         check("wea_on_handshake", 32'(ram_wea3), 32'(hs_in));
         check("ena_on_handshake", 32'(ram_ena3), 32'(hs_in));
         check("web_tied", 32'(ram_web3), 32'd0);
         if (hs_in) begin
            check("addra_bitrev", 32'(ram_addra3), 32'(rev8[wr_seen]));
            check("dina", 32'(ram_dina3), 32'(s_data3));
         end
         if (prev_stall) begin
            check("stall_valid", 32'(m_valid3), 32'd1);
            check("stall_data", 32'(m_data3), 32'(prev_data));
            check("stall_last", 32'(m_last3), 32'(prev_last));
         end
         check("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
         if (ram_enb3) begin
            check("addrb_seq", 32'(ram_addrb3), 32'(issued % 8));
            issued++;
         end
         if (m_valid3 && m_ready3) begin
            got_d.push_back(m_data3);
            got_l.push_back(m_last3);
            popped++;
         end
         prev_stall = m_valid3 && !m_ready3;
         prev_data  = m_data3;
         prev_last  = m_last3;
         if (hs_in) begin
            if (wr_seen == 7) begin
               busy_exp = 1'b1;
               wr_seen  = 0;
            end else begin
               wr_seen++;
            end
         end
         if (m_valid3 && m_ready3 && m_last3) begin
            busy_exp = 1'b0;
            issued   = 0;
            popped   = 0;
         end
      end
   end

   // ------------------------------------------------------------ N=8 tasks
   // All tasks start and end 1 time unit after a rising edge.
   task automatic push3(input logic [15:0] d, input int gap);
      int t = 0;
      s_valid3 = 1'b1;
      s_data3  = d;
      @(negedge clk);
      while (!s_ready3 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s_valid3 = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame3(input logic [15:0] base, input int gap);
      for (int i = 0; i < 8; i++) push3(base + 16'(i), gap);
   endtask

   // mode 0: m_ready held high; mode 1: two 5-cycle stalls plus random toggling.
   // junk: hold s_valid high with changing data while draining.
   task automatic drain3(input int mode, input bit junk);
      int cyc = 0;
      while (got_d.size() < 8 && cyc < 300) begin
         if (mode == 0)                        m_ready3 = 1'b1;
         else if ((cyc >= 3 && cyc < 8) ||
                  (cyc >= 12 && cyc < 17))     m_ready3 = 1'b0;
         else                                  m_ready3 = 1'($urandom_range(0, 1));
         if (junk) begin
            s_valid3 = 1'b1;
            s_data3  = 16'($urandom);
         end
         @(posedge clk); #1;
         cyc++;
      end
      s_valid3 = 1'b0;
      m_ready3 = 1'b1;
      if (cyc >= 300) check("drain_timeout", 32'd0, 32'd1);
      check("s_ready_after_last", 32'(s_ready3), 32'd1);
   endtask

   task automatic compare3(input string tag, input logic [15:0] base);
      check({tag, "_count"}, 32'(got_d.size()), 32'd8);
      for (int k = 0; k < 8 && k < got_d.size(); k++) begin
         check($sformatf("%s_data%0d", tag, k), 32'(got_d[k]), 32'(base + 16'(rev8[k])));
         check($sformatf("%s_last%0d", tag, k), 32'(got_l[k]), 32'(k == 7));
      end
      got_d.delete();
      got_l.delete();
   endtask

   task automatic check_reset3(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready3), 32'd0);
      check({tag, "_m_valid"}, 32'(m_valid3), 32'd0);
      check({tag, "_m_last"},  32'(m_last3),  32'd0);
      check({tag, "_m_data"},  32'(m_data3),  32'd0);
      check({tag, "_busy"},    32'(busy3),    32'd0);
      check({tag, "_ram"}, 32'({ram_ena3, ram_wea3, ram_enb3, ram_web3, ram_addra3,
                                ram_addrb3, ram_dina3}), 32'd0);
   endtask

   // ------------------------------------------------------------------ main
   initial begin
      int cyc, first_busy, first_valid, n_out, gaps, miss, last_idx, n_last;
      logic [15:0] o0, o1, o2, o3, o1023;

      rst3 = 1'b1; s_valid3 = 1'b0; s_data3 = '0; m_ready3 = 1'b1;
      rst10 = 1'b1; s_valid10 = 1'b0; s_data10 = '0; m_ready10 = 1'b1;
      #2;
      check_reset3("reset");
      repeat (2) @(posedge clk);
      #1;
      rst3 = 1'b0; rst10 = 1'b0;
      check("s_ready_before_edge", 32'(s_ready3), 32'd0);
      @(posedge clk); #1;
      check("s_ready_after_reset", 32'(s_ready3), 32'd1);
      check("s_ready10_after_reset", 32'(s_ready10), 32'd1);

      // ---- 1024-point stream, value = index, sink always ready
      miss = 0;
      s_valid10 = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         s_data10 = 16'(i);
         if (!s_ready10) miss++;
         @(posedge clk); #1;
      end
      s_valid10 = 1'b0;
      check("n1024_ready_stream", 32'(miss), 32'd0);
      cyc = 0; first_busy = -1; first_valid = -1; n_out = 0; gaps = 0;
      last_idx = -1; n_last = 0;
      o0 = '1; o1 = '0; o2 = '0; o3 = '0; o1023 = '0;
      while (n_out < 1024 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (busy10 && first_busy < 0) first_busy = cyc;
         if (m_valid10) begin
            if (first_valid < 0) first_valid = cyc;
            if (n_out == 0)    o0    = m_data10;
            if (n_out == 1)    o1    = m_data10;
            if (n_out == 2)    o2    = m_data10;
            if (n_out == 3)    o3    = m_data10;
            if (n_out == 1023) o1023 = m_data10;
            if (m_last10) begin
               last_idx = n_out;
               n_last++;
            end
            n_out++;
         end else if (first_valid >= 0) begin
            gaps++;
         end
      end
      check("n1024_count", 32'(n_out), 32'd1024);
      check("n1024_busy_first_cycle", 32'(first_busy), 32'd1);
      check("n1024_latency", 32'(first_valid - first_busy), 32'd2);
      check("n1024_gaps", 32'(gaps), 32'd0);
      check("n1024_out0", 32'(o0), 32'd0);
      check("n1024_out1", 32'(o1), 32'd512);
      check("n1024_out2", 32'(o2), 32'd256);
      check("n1024_out3", 32'(o3), 32'd768);
      check("n1024_out1023", 32'(o1023), 32'd1023);
      check("n1024_last_idx", 32'(last_idx), 32'd1023);
      check("n1024_last_once", 32'(n_last), 32'd1);
      @(posedge clk); #1;
      check("n1024_busy_cleared", 32'(busy10), 32'd0);
      check("n1024_ready_again", 32'(s_ready10), 32'd1);

      // ---- 8-point back-to-back frame, sink always ready
      send_frame3(16'h0000, 0);
      drain3(0, 1'b0);
      compare3("basic", 16'h0000);

      // ---- backpressure with random toggling and 5-cycle stalls
      send_frame3(16'h0100, 0);
      drain3(1, 1'b0);
      compare3("backpressure", 16'h0100);

      // ---- input held valid with changing data during drain
      send_frame3(16'h0200, 0);
      drain3(0, 1'b1);
      compare3("junk_drain", 16'h0200);
      send_frame3(16'h0300, 0);
      drain3(0, 1'b0);
      compare3("after_junk", 16'h0300);

      // ---- reset after 3 writes
      push3(16'h0400, 0);
      push3(16'h0401, 0);
      push3(16'h0402, 0);
      #1 rst3 = 1'b1;
      #1 check_reset3("rst_load");
      @(posedge clk); #1;
      rst3 = 1'b0;
      @(posedge clk); #1;

      // ---- reset mid-drain after 2 outputs
      send_frame3(16'h0500, 0);
      cyc = 0;
      while (got_d.size() < 2 && cyc < 50) begin
         m_ready3 = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      check("mid_drain_reached", 32'(got_d.size()), 32'd2);
      check("mid_drain_busy", 32'(busy3), 32'd1);
      #1 rst3 = 1'b1;
      #1 check_reset3("rst_drain");
      @(posedge clk); #1;
      rst3 = 1'b0;
      @(posedge clk); #1;
      send_frame3(16'h0600, 0);
      drain3(0, 1'b0);
      compare3("after_reset", 16'h0600);

      // ---- gapped input, one valid cycle in three
      send_frame3(16'h0700, 2);
      drain3(0, 1'b0);
      compare3("gapped", 16'h0700);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
